goldschmidt_sched: RTL and testbench
====================================

Name: goldschmidt_sched

Overview:
Start/done sequencer for the shared Goldschmidt divide/square-root datapath.
- Replaces the free-running division and square-root counters with one controller.
- Accepts an operation request and latches the op code.
- Steps the datapath through the fixed division (12-step) or square-root (16-step) schedule, then signals completion.
- Sits between the FPU issue logic and the goldschmidt datapath; drives all of the datapath's mux selects and register enables.

Parameters:
DIV_STEPS, 12, division schedule length in cycles (fixed by the datapath iteration count).
SQRT_STEPS, 16, square-root schedule length in cycles.
CNT_W, 4, step counter width; must satisfy 2^CNT_W >= max(DIV_STEPS, SQRT_STEPS).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op_in  input  2  operation: 00 = divide, any nonzero value = square root
abort  input  1  cancel in-flight operation (only present with GS_ABORT_EN)
op  output  2  latched op code, drives the datapath op input
sA  output  2  datapath A-operand select
sB  output  2  datapath B-operand select
cloneA  output  1  datapath B = A (squaring) select
enableN  output  1  N register load enable
enableD  output  1  D register load enable
enableK  output  1  K register load enable
enableQD  output  1  QD register load enable
busy  output  1  high during RUN
done  output  1  one-cycle pulse; datapath result and r_sign are valid this cycle

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it forces IDLE, count=0, op=00, and all outputs 0. Reset mid-RUN abandons the operation; no done pulse is produced.
- States:
  - IDLE: start=1 -> RUN, count=0, op<=op_in.
  - RUN: count increments each cycle. At the last step (count = DIV_STEPS-1 or SQRT_STEPS-1) -> DONE.
  - DONE: done=1 for exactly one cycle. start=1 -> RUN with count=0 (back-to-back issue); otherwise -> IDLE.
- busy=1 only in RUN. start is ignored while busy=1. op is held constant from the accepted start until the next accepted start.
- IDLE/DONE outputs: sA=00, sB=00, cloneA=0, all enables 0. The datapath registers therefore hold the result through DONE and IDLE.
- Division schedule, step c in 0..11:
  - rem = (c==11); mode = (2<=c<11); stage = c[0].
  - sA = {rem, mode}; sB = {mode, stage}.
  - enableN = ~stage; enableD = enableK = stage; enableQD = rem; cloneA = 0.
- Square-root schedule, step c in 0..15, given as cloneA/sA/sB:
  - 0: 0/00/00
  - 1: 1/00/00
  - 2: 0/01/00
  - 3: 0/01/10
  - 4, 7, 10, 13: 1/01/00
  - 5, 8, 11, 14: 0/01/11
  - 6, 9, 12, 15: 0/01/10
- Square-root enables by c mod 3 ({N, D, K, QD}): 0 -> 1000; 1 -> 0010; 2 -> 0110. enableQD is never asserted for square root.
- Latency: accepted start at cycle T gives done at T+1+DIV_STEPS (division) or T+1+SQRT_STEPS (square root).
- All outputs are decoded combinationally from registered state, count and op. There are no combinational paths from any input to any output.
- The counter never wraps. Any count value beyond the schedule length is unreachable and is treated as the last step.

Optional Feature:
GS_ABORT_EN
- Defined: the abort port exists. abort=1 in RUN returns to IDLE on the next edge with no done pulse; outputs are IDLE values from that edge onward. abort has priority over the last-step transition to DONE. abort in IDLE/DONE is ignored. start and abort in the same IDLE cycle: start wins.
- Undefined: no abort port; RUN always completes.

Test Plan:
- Reset then divide: start=1, op_in=00 at cycle 0. Required:
  - busy=1 for cycles 1-12.
  - Step 0: sA=00, sB=00, enableN=1.
  - Step 11: sA=10, sB=01, enableD=enableK=enableQD=1.
  - done=1 only at cycle 13; with n0=1.5, d0=1.25 loaded, the datapath result is ≈1.2.
- Square root: op_in=01. Required:
  - Step 1: cloneA=1, enables=0010.
  - Step 5: sA=01, sB=11, enables=0110.
  - done at cycle 17; with n0=0.5625 the result is ≈0.75; enableQD never 1.
- Back-to-back: start held high. Required: DONE cycle accepts the next request, step 0 follows immediately, no IDLE gap; op changes only at acceptance.
- Start while busy: pulse start with op_in=01 at step 4 of a divide. Required: ignored, op stays 00, done at cycle 13.
- Async reset mid-RUN at square-root step 7, deasserted between edges. Required: all outputs 0 immediately, no done, a new start is accepted normally.
- GS_ABORT_EN: abort at division step 6. Required: busy=0 and enables 0 next cycle, no done; abort held in IDLE has no effect.

Source files
------------

// File: rtl/goldschmidt_sched.sv
// Start/done sequencer driving the shared Goldschmidt divide/sqrt datapath selects and enables.
// Optional abort input is compiled in when GS_ABORT_EN is defined.
module goldschmidt_sched #(
  parameter int DIV_STEPS  = 12,
  parameter int SQRT_STEPS = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op_in,
`ifdef GS_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] op,
  output logic [1:0] sA,
  output logic [1:0] sB,
  output logic       cloneA,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(SQRT_STEPS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [8:0]       ctl_q;
  logic             busy_q, done_q;
  logic             abort_w;
  logic [CNT_W-1:0] last_step;

`ifdef GS_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Control word layout: {sA, sB, cloneA, enableN, enableD, enableK, enableQD}.
  function automatic logic [8:0] decode(state_t s, logic [CNT_W-1:0] c, logic [1:0] o);
    logic [CNT_W-1:0] cc;
    logic             rem, mode, stage;
    logic [1:0]       m3;
    logic [1:0]       a_sel, b_sel;
    logic             clone;
    logic [3:0]       en;
    int               ci;
    a_sel = 2'b00;
    b_sel = 2'b00;
    clone = 1'b0;
    en    = 4'b0000;
    if (s == RUN) begin
      if (o == 2'b00) begin
        cc    = (c > DIV_LAST) ? DIV_LAST : c;
        rem   = (cc == DIV_LAST);
        mode  = (cc >= CNT_W'(2)) && (cc < DIV_LAST);
        stage = cc[0];
        a_sel = {rem, mode};
        b_sel = {mode, stage};
        en    = {~stage, stage, stage, rem};
      end else begin
        cc = (c > SQRT_LAST) ? SQRT_LAST : c;
        ci = int'(cc);
        m3 = 2'(ci % 3);
        case (m3)
          2'd0:    en = 4'b1000;
          2'd1:    en = 4'b0010;
          2'd2:    en = 4'b0110;
          default: en = 4'b0000;
        endcase
        if (ci == 0) begin
          a_sel = 2'b00; b_sel = 2'b00; clone = 1'b0;
        end else if (ci == 1) begin
          a_sel = 2'b00; b_sel = 2'b00; clone = 1'b1;
        end else if (ci == 2) begin
          a_sel = 2'b01; b_sel = 2'b00; clone = 1'b0;
        end else if (ci == 3) begin
          a_sel = 2'b01; b_sel = 2'b10; clone = 1'b0;
        end else begin
          // Steady three-step loop: square, multiply, refine.
          a_sel = 2'b01;
          case (m3)
            2'd1:    begin b_sel = 2'b00; clone = 1'b1; end
            2'd2:    begin b_sel = 2'b11; clone = 1'b0; end
            default: begin b_sel = 2'b10; clone = 1'b0; end
          endcase
        end
      end
    end
    return {a_sel, b_sel, clone, en};
  endfunction

  assign last_step = (op_q == 2'b00) ? DIV_LAST : SQRT_LAST;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          op_d    = op_in;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q >= last_step) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        count_d = '0;
        if (start) begin
          state_d = RUN;
          op_d    = op_in;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 2'b00;
      ctl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      ctl_q   <= decode(state_d, count_d, op_d);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign op       = op_q;
  assign sA       = ctl_q[8:7];
  assign sB       = ctl_q[6:5];
  assign cloneA   = ctl_q[4];
  assign enableN  = ctl_q[3];
  assign enableD  = ctl_q[2];
  assign enableK  = ctl_q[1];
  assign enableQD = ctl_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));
  a_sqrt_no_qd:     assert property (@(posedge clk) disable iff (reset) (op != 2'b00) |-> !enableQD);

endmodule

// File: tb/tb_goldschmidt_sched.sv
// Scoreboard bench for goldschmidt_sched: stimulus pushes expected per-cycle control words, a negedge monitor pops and compares.
module tb_goldschmidt_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op_in;
  logic       abort;
  logic [1:0] op, sA, sB;
  logic       cloneA, enableN, enableD, enableK, enableQD, busy, done;

  always #5 clk = ~clk;

  goldschmidt_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_in    (op_in),
`ifdef GS_ABORT_EN
    .abort    (abort),
`endif
    .op       (op),
    .sA       (sA),
    .sB       (sB),
    .cloneA   (cloneA),
    .enableN  (enableN),
    .enableD  (enableD),
    .enableK  (enableK),
    .enableQD (enableQD),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int          cyc;
    logic [12:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // {sA, sB, cloneA, enableN, enableD, enableK, enableQD}
  logic [8:0] div_tbl [12] = '{
    9'b00_00_0_1000, 9'b00_01_0_0110, 9'b01_10_0_1000, 9'b01_11_0_0110,
    9'b01_10_0_1000, 9'b01_11_0_0110, 9'b01_10_0_1000, 9'b01_11_0_0110,
    9'b01_10_0_1000, 9'b01_11_0_0110, 9'b01_10_0_1000, 9'b10_01_0_0111
  };
  logic [8:0] sqrt_tbl [16] = '{
    9'b00_00_0_1000, 9'b00_00_1_0010, 9'b01_00_0_0110, 9'b01_10_0_1000,
    9'b01_00_1_0010, 9'b01_11_0_0110, 9'b01_10_0_1000, 9'b01_00_1_0010,
    9'b01_11_0_0110, 9'b01_10_0_1000, 9'b01_00_1_0010, 9'b01_11_0_0110,
    9'b01_10_0_1000, 9'b01_00_1_0010, 9'b01_11_0_0110, 9'b01_10_0_1000
  };

  // {busy, done, op, sA, sB, cloneA, enN, enD, enK, enQD}
  logic [12:0] act;
  assign act = {busy, done, op, sA, sB, cloneA, enableN, enableD, enableK, enableQD};
  localparam logic [12:0] IDLE_MASK = 13'b1_1_00_11_11_1_1111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_v(input string name, input logic [12:0] a, input logic [12:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, a, e, cyc);
    end
  endtask

  task automatic check_i(input string name, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy || done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %b expected idle (cycle %0d)", act, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check_i("step_cycle", cyc, mon_e.cyc);
          check_v("step_ctl", act, mon_e.v);
        end
      end else begin
        check_v("idle_ctl", act & IDLE_MASK, 13'b0);
      end
    end
  end

  // Called just after a rising edge; asserts start for one edge and queues the expected trace.
  task automatic issue(input logic [1:0] opv, input int npush, input bit push_done);
    int         n;
    logic [8:0] row;
    exp_t       e;
    n = (opv == 2'b00) ? 12 : 16;
    for (int t = 0; t < npush; t++) begin
      row   = (opv == 2'b00) ? div_tbl[t] : sqrt_tbl[t];
      e.cyc = cyc + 1 + t;
      e.v   = {1'b1, 1'b0, opv, row};
      sb_q.push_back(e);
    end
    if (push_done) begin
      e.cyc = cyc + 1 + n;
      e.v   = {1'b0, 1'b1, opv, 9'b0};
      sb_q.push_back(e);
    end
    start = 1'b1;
    op_in = opv;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    op_in = 2'b10;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_in = 2'b00;
    abort = 1'b0;
    #12;
    check_v("reset_state", act, 13'b0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Plain divide then plain square root.
    issue(2'b00, 12, 1'b1);
    repeat (14) @(posedge clk);
    #1;
    issue(2'b01, 16, 1'b1);
    repeat (18) @(posedge clk);
    #1;

    // Back-to-back: start held high through RUN, next request taken in DONE.
    issue(2'b00, 12, 1'b1);
    start = 1'b1;
    op_in = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    issue(2'b11, 16, 1'b1);
    repeat (18) @(posedge clk);
    #1;

    // Start pulse at divide step 4 must be ignored.
    issue(2'b00, 12, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op_in = 2'b01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Async reset at square-root step 7, released between edges.
    issue(2'b01, 8, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_v("async_reset", act, 13'b0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(2'b00, 12, 1'b1);
    repeat (14) @(posedge clk);
    #1;

`ifdef GS_ABORT_EN
    // Abort at divide step 6, abort held in IDLE, then start wins alongside abort.
    issue(2'b00, 7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    issue(2'b01, 16, 1'b1);
    repeat (18) @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check_i("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
